icu_core_v2: RTL and testbench
==============================

# icu_core_v2

Parametrised successor to the MC14500B-style industrial control unit. It widens the result register and data memory from 1 bit to DATA_W bits and adds a hardware call/return stack. It also provides an external I/O port, an explicit LOAD/RUN/HALT state machine, and executes one instruction per clock. It sits at the top of the controller, with an internal program ROM and data RAM that both use combinational read and synchronous write.

## Interface
- ADDR, 8, address width; ROM and RAM depth = 2^ADDR
- CODE, 4, opcode width; fixed at 4
- WORD, ADDR+CODE, instruction width; opcode in [WORD-1:ADDR], operand address in [ADDR-1:0]
- DATA_W, 8, width of RR, RAM words and I/O port; must be ≥1
- STACK_DEPTH, 4, number of return-address entries; must be ≥1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- prog_we  in  1  program write strobe; honoured only in LOAD
- prog_addr  in  ADDR  ROM write address
- prog_data  in  WORD  ROM write data
- start  in  1  LOAD→RUN
- stop  in  1  RUN→LOAD
- din  in  DATA_W  external input, read at address 2^ADDR−2
- dout  out  DATA_W  external output register, written at address 2^ADDR−2
- opcode  out  CODE  opcode of the instruction at pc (instruction_t)
- pc  out  ADDR  program counter
- rr  out  DATA_W  result register
- flag_o, flag_f  out  1  one-cycle pulses for NOP0 / NOPF
- jmp_flag, rtn_flag  out  1  one-cycle pulses on an executed JMP / RTN
- running  out  1  state==RUN
- err  out  2  sticky; bit0 stack overflow, bit1 stack underflow

## Operation
- States: LOAD (reset state), RUN, HALT.
  - LOAD→RUN on start; pc←0 on entry.
  - RUN→LOAD on stop; the instruction in that cycle is not executed.
  - RUN→HALT on a stack error. HALT exits only via rst.
- ROM and RAM contents are unaffected by rst. prog_we outside LOAD is ignored.
- Operand D by address a:
  - a=2^ADDR−1 → D=rr
  - a=2^ADDR−2 → D=din
  - otherwise D=RAM[a]
- When IEN=0, D is forced to 0 for LD/LDC/AND/ANDC/OR/ORC/XNOR.
- Opcodes 0–F (all logic is bitwise over DATA_W):
  - NOP0: flag_o pulse
  - LD: rr←D
  - LDC: rr←~D
  - AND: rr&=D
  - ANDC: rr&=~D
  - OR: rr|=D
  - ORC: rr|=~D
  - XNOR: rr←~(rr^D)
  - STO: M[a]←rr
  - STOC: M[a]←~rr
  - IEN: IEN←D[0], ungated
  - OEN: OEN←D[0], ungated
  - JMP: push pc+1, pc←a
  - RTN: pop into pc
  - SKZ: skip next if rr==0 (all bits)
  - NOPF: flag_f pulse
- STO/STOC write only when OEN=1.
  - a=2^ADDR−2 writes dout.
  - a=2^ADDR−1 writes are discarded.
- Skip: the skipped instruction occupies one cycle with no side effects. It produces no flags, no pushes and no writes, and pc still advances by 1.
- Stack errors:
  - JMP with a full stack: err[0]←1, HALT, pc unchanged.
  - RTN with an empty stack: err[1]←1, HALT, pc unchanged.
- pc increments modulo 2^ADDR. Pushing pc+1 from 2^ADDR−1 stores 0.

## Timing
- One instruction per clk in RUN. Effects of the instruction at pc are visible after that rising edge.
- rr forwarding: an instruction reading a=2^ADDR−1 sees rr as updated by the previous instruction.
- RAM read-after-write: a STO at cycle n is visible to a load at cycle n+1.
- Flag pulses are registered and high exactly one cycle, the cycle after execution.
- Reset values:
  - state=LOAD, pc=0, rr=0, dout=0
  - IEN=1, OEN=1
  - stack pointer=0 (empty), skip=0, err=0
  - all flags 0, running=0
- start and stop are sampled only in LOAD and RUN respectively. start in RUN and stop in LOAD are ignored.
- rst has priority over start, stop and prog_we in the same cycle.
- rst mid-RUN aborts the current instruction; its write does not occur.

## Test plan
- ALU/I/O: load LD 0xFE; ANDC 0xFE; OR 0xFE; STO 0xFE with din=0xA5 and start. Required: rr=0xA5, then 0x00, then 0xA5; dout=0xA5 after cycle 4; running=1.
- Gating:
  - Program IEN (din=0x00) → LD 0xFE with din=0xFF gives rr=0x00.
  - With OEN=0, STO to RAM[0x10] leaves the word unchanged on readback after OEN=1.
- SKZ:
  - rr=0x00; SKZ; JMP 0x40 → JMP is skipped, pc=3, jmp_flag stays 0, stack empty.
  - rr=0x01 → JMP is taken, pc=0x40, jmp_flag pulses once.
- Call/return: JMP 0x20 at pc=5; RTN at 0x20 → pc=6; nested calls to depth STACK_DEPTH=4 return in LIFO order.
- Errors:
  - Fifth nested JMP → err=01, running=0, pc holds.
  - RTN with an empty stack → err=10.
  - Only rst clears either error; after rst err=00 and state=LOAD.
- Control: prog_we during RUN leaves the ROM unchanged; stop mid-program → LOAD, dout keeps its value; rst while STO is at pc leaves dout=0.

Source files
------------

// File: rtl/icu_core_v2_if.sv
// Program-load bus of icu_core_v2: the host writes instruction words into the
// internal ROM over this bus while the core sits in LOAD.
interface icu_core_v2_if #(
  parameter int ADDR = 8,
  parameter int CODE = 4
);
  localparam int WORD = ADDR + CODE;

  logic            prog_we;
  logic [ADDR-1:0] prog_addr;
  logic [WORD-1:0] prog_data;

  modport master (output prog_we, prog_addr, prog_data);
  modport slave  (input  prog_we, prog_addr, prog_data);
endinterface

// File: rtl/icu_core_v2.sv
// DATA_W-wide MC14500B-style control unit: one instruction per clock from an
// internal ROM, bitwise result register, data RAM, I/O port and call stack.
module icu_core_v2 #(
  parameter int ADDR        = 8,
  parameter int CODE        = 4,
  parameter int WORD        = ADDR + CODE,
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  icu_core_v2_if.slave      prog,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CODE-1:0]   opcode,
  output logic [ADDR-1:0]   pc,
  output logic [DATA_W-1:0] rr,
  output logic              flag_o,
  output logic              flag_f,
  output logic              jmp_flag,
  output logic              rtn_flag,
  output logic              running,
  output logic [1:0]        err
);

  typedef enum logic [3:0] {
    NOP0 = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } instruction_t;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR-1:0] A_RR    = '1;
  localparam logic [ADDR-1:0] A_IO    = ~ADDR'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [WORD-1:0]   rom   [2**ADDR];
  logic [DATA_W-1:0] ram   [2**ADDR];
  logic [ADDR-1:0]   stack [STACK_DEPTH];

  state_t            state;
  logic [SP_W-1:0]   sp;
  logic              ien, oen, skip;

  logic [WORD-1:0]   instr;
  instruction_t      op;
  logic [ADDR-1:0]   a;
  logic [DATA_W-1:0] d, dg;
  logic [ADDR-1:0]   pc_inc;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic              exec;

  assign instr    = rom[pc];
  assign op       = instruction_t'(instr[WORD-1:ADDR]);
  assign a        = instr[ADDR-1:0];
  assign opcode   = instr[WORD-1:ADDR];
  assign pc_inc   = pc + ADDR'(1);
  assign sp_dec   = sp - SP_W'(1);
  assign push_idx = sp[IDX_W-1:0];
  assign pop_idx  = sp_dec[IDX_W-1:0];
  assign running  = (state == S_RUN);
  // A stop or a pending skip both suppress every side effect of the word at pc.
  assign exec     = (state == S_RUN) && !stop && !skip;

  always_comb begin
    if (a == A_RR)      d = rr;
    else if (a == A_IO) d = din;
    else                d = ram[a];
    dg = ien ? d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_LOAD && prog.prog_we)
      rom[prog.prog_addr] <= prog.prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && exec && oen && (op == STO || op == STOC) && a != A_RR && a != A_IO)
      ram[a] <= (op == STOC) ? ~rr : rr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      pc       <= '0;
      rr       <= '0;
      dout     <= '0;
      ien      <= 1'b1;
      oen      <= 1'b1;
      sp       <= '0;
      skip     <= 1'b0;
      err      <= 2'b00;
      flag_o   <= 1'b0;
      flag_f   <= 1'b0;
      jmp_flag <= 1'b0;
      rtn_flag <= 1'b0;
    end else begin
      flag_o   <= 1'b0;
      flag_f   <= 1'b0;
      jmp_flag <= 1'b0;
      rtn_flag <= 1'b0;
      case (state)
        S_LOAD: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
            skip  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_LOAD;
          end else if (skip) begin
            skip <= 1'b0;
            pc   <= pc_inc;
          end else begin
            pc <= pc_inc;
            case (op)
              NOP0: flag_o <= 1'b1;
              LD:   rr <= dg;
              LDC:  rr <= ~dg;
              AND:  rr <= rr & dg;
              ANDC: rr <= rr & ~dg;
              OR:   rr <= rr | dg;
              ORC:  rr <= rr | ~dg;
              XNOR: rr <= ~(rr ^ dg);
              STO:  if (oen && a == A_IO) dout <= rr;
              STOC: if (oen && a == A_IO) dout <= ~rr;
              IEN:  ien <= d[0];
              OEN:  oen <= d[0];
              JMP: begin
                if (sp == SP_FULL) begin
                  err[0] <= 1'b1;
                  state  <= S_HALT;
                  pc     <= pc;
                end else begin
                  stack[push_idx] <= pc_inc;
                  sp              <= sp + SP_W'(1);
                  pc              <= a;
                  jmp_flag        <= 1'b1;
                end
              end
              RTN: begin
                if (sp == '0) begin
                  err[1] <= 1'b1;
                  state  <= S_HALT;
                  pc     <= pc;
                end else begin
                  pc       <= stack[pop_idx];
                  sp       <= sp_dec;
                  rtn_flag <= 1'b1;
                end
              end
              SKZ:  skip <= (rr == '0);
              NOPF: flag_f <= 1'b1;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icu_core_v2.sv
// Directed-vector bench for icu_core_v2: small hand-assembled programs with
// hand-computed register, port, flag and error values.
module tb_icu_core_v2;

  localparam int ADDR        = 8;
  localparam int CODE        = 4;
  localparam int WORD        = ADDR + CODE;
  localparam int DATA_W      = 8;
  localparam int STACK_DEPTH = 4;

  localparam logic [3:0] OP_NOP0 = 4'h0, OP_LD  = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4, OP_OR  = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN = 4'hA, OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC, OP_RTN = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF;

  logic              clk = 1'b0;
  logic              rst, start, stop;
  logic [DATA_W-1:0] din, dout, rr;
  logic [CODE-1:0]   opcode;
  logic [ADDR-1:0]   pc;
  logic              flag_o, flag_f, jmp_flag, rtn_flag, running;
  logic [1:0]        err;
  int                checks = 0;
  int                failures = 0;

  icu_core_v2_if #(.ADDR(ADDR), .CODE(CODE)) prog_bus ();

  icu_core_v2 #(
    .ADDR(ADDR), .CODE(CODE), .WORD(WORD), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .prog(prog_bus), .start(start), .stop(stop),
    .din(din), .dout(dout), .opcode(opcode), .pc(pc), .rr(rr),
    .flag_o(flag_o), .flag_f(flag_f), .jmp_flag(jmp_flag), .rtn_flag(rtn_flag),
    .running(running), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic progWord(input logic [7:0] addr, input logic [3:0] op, input logic [7:0] opnd);
    prog_bus.prog_we   = 1'b1;
    prog_bus.prog_addr = addr;
    prog_bus.prog_data = {op, opnd};
    applyStimulus(1);
    prog_bus.prog_we   = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
  endtask

  task automatic startRun();
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
  endtask

  logic [7:0] call_seq [10] = '{8'h20, 8'h06, 8'h30, 8'h40, 8'h50, 8'h60, 8'h51, 8'h41, 8'h31, 8'h07};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; din = '0;
    prog_bus.prog_we = 1'b0; prog_bus.prog_addr = '0; prog_bus.prog_data = '0;
    applyStimulus(2);
    rst = 1'b0;
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_rr", 32'(rr), 32'h0);
    checkOutput("rst_dout", 32'(dout), 32'h0);
    checkOutput("rst_running", 32'(running), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_flags", 32'({flag_o, flag_f, jmp_flag, rtn_flag}), 32'h0);

    // rst wins over start in the same cycle
    rst = 1'b1; start = 1'b1;
    applyStimulus(1);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_over_start", 32'(running), 32'h0);

    // ALU and I/O port
    progWord(8'h00, OP_LD,   8'hFE);
    progWord(8'h01, OP_ANDC, 8'hFE);
    progWord(8'h02, OP_OR,   8'hFE);
    progWord(8'h03, OP_STO,  8'hFE);
    din = 8'hA5;
    startRun();
    checkOutput("alu_running", 32'(running), 32'h1);
    checkOutput("alu_opcode0", 32'(opcode), 32'(OP_LD));
    applyStimulus(1);
    checkOutput("alu_ld", 32'(rr), 32'hA5);
    applyStimulus(1);
    checkOutput("alu_andc", 32'(rr), 32'h00);
    applyStimulus(1);
    checkOutput("alu_or", 32'(rr), 32'hA5);
    applyStimulus(1);
    checkOutput("alu_dout", 32'(dout), 32'hA5);
    checkOutput("alu_pc", 32'(pc), 32'h04);

    // IEN gating, and IEN itself reads ungated
    doReset();
    progWord(8'h00, OP_LD,  8'hFE);
    progWord(8'h01, OP_IEN, 8'hFE);
    progWord(8'h02, OP_LD,  8'hFE);
    progWord(8'h03, OP_IEN, 8'hFE);
    progWord(8'h04, OP_LD,  8'hFE);
    startRun();
    din = 8'hFF; applyStimulus(1);
    checkOutput("ien_ld_on", 32'(rr), 32'hFF);
    din = 8'h00; applyStimulus(1);
    din = 8'hFF; applyStimulus(1);
    checkOutput("ien_ld_gated", 32'(rr), 32'h00);
    applyStimulus(2);
    checkOutput("ien_restored", 32'(rr), 32'hFF);

    // OEN gating, RAM read-after-write, forwarding, AND/ORC/STOC
    doReset();
    progWord(8'h00, OP_LD,   8'hFE);
    progWord(8'h01, OP_STO,  8'h10);
    progWord(8'h02, OP_LDC,  8'h10);
    progWord(8'h03, OP_OEN,  8'hFE);
    progWord(8'h04, OP_STO,  8'h10);
    progWord(8'h05, OP_STO,  8'hFE);
    progWord(8'h06, OP_OEN,  8'hFE);
    progWord(8'h07, OP_LD,   8'h10);
    progWord(8'h08, OP_XNOR, 8'hFF);
    progWord(8'h09, OP_AND,  8'hFE);
    progWord(8'h0A, OP_ORC,  8'hFE);
    progWord(8'h0B, OP_STOC, 8'hFE);
    startRun();
    din = 8'h3C; applyStimulus(3);
    checkOutput("raw_ldc", 32'(rr), 32'hC3);
    din = 8'h00; applyStimulus(3);
    checkOutput("oen_dout_blocked", 32'(dout), 32'h00);
    din = 8'h01; applyStimulus(2);
    checkOutput("oen_ram_kept", 32'(rr), 32'h3C);
    applyStimulus(1);
    checkOutput("xnor_fwd", 32'(rr), 32'hFF);
    din = 8'h0F; applyStimulus(1);
    checkOutput("and", 32'(rr), 32'h0F);
    din = 8'h3C; applyStimulus(1);
    checkOutput("orc", 32'(rr), 32'hCF);
    applyStimulus(1);
    checkOutput("stoc_dout", 32'(dout), 32'h30);

    // SKZ taken over a JMP, then RTN on empty stack
    doReset();
    progWord(8'h00, OP_LD,  8'hFE);
    progWord(8'h01, OP_SKZ, 8'h00);
    progWord(8'h02, OP_JMP, 8'h40);
    progWord(8'h03, OP_RTN, 8'h00);
    progWord(8'h40, OP_NOP0, 8'h00);
    din = 8'h00;
    startRun();
    applyStimulus(3);
    checkOutput("skz_pc", 32'(pc), 32'h03);
    checkOutput("skz_no_jmp_flag", 32'(jmp_flag), 32'h0);
    applyStimulus(1);
    checkOutput("underflow_err", 32'(err), 32'h2);
    checkOutput("underflow_running", 32'(running), 32'h0);
    checkOutput("underflow_pc", 32'(pc), 32'h03);
    doReset();
    checkOutput("underflow_cleared", 32'(err), 32'h0);

    // SKZ not taken: JMP executes
    din = 8'h01;
    startRun();
    applyStimulus(3);
    checkOutput("jmp_pc", 32'(pc), 32'h40);
    checkOutput("jmp_flag_hi", 32'(jmp_flag), 32'h1);
    applyStimulus(1);
    checkOutput("jmp_flag_lo", 32'(jmp_flag), 32'h0);
    checkOutput("nop0_flag", 32'(flag_o), 32'h1);

    // Call/return and LIFO nesting to full depth
    doReset();
    for (int i = 0; i < 5; i++) progWord(8'(i), OP_NOP0, 8'h00);
    progWord(8'h05, OP_JMP, 8'h20);
    progWord(8'h20, OP_RTN, 8'h00);
    progWord(8'h06, OP_JMP, 8'h30);
    progWord(8'h30, OP_JMP, 8'h40);
    progWord(8'h40, OP_JMP, 8'h50);
    progWord(8'h50, OP_JMP, 8'h60);
    progWord(8'h60, OP_RTN, 8'h00);
    progWord(8'h51, OP_RTN, 8'h00);
    progWord(8'h41, OP_RTN, 8'h00);
    progWord(8'h31, OP_RTN, 8'h00);
    startRun();
    applyStimulus(5);
    checkOutput("call_pc_5", 32'(pc), 32'h05);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("call_seq_%0d", i), 32'(pc), 32'(call_seq[i]));
    end
    checkOutput("call_rtn_flag", 32'(rtn_flag), 32'h1);
    checkOutput("call_err", 32'(err), 32'h0);

    // Fifth nested JMP overflows; HALT ignores start
    doReset();
    progWord(8'h60, OP_JMP, 8'h70);
    startRun();
    applyStimulus(11);
    checkOutput("ovf_pre_pc", 32'(pc), 32'h60);
    applyStimulus(1);
    checkOutput("ovf_err", 32'(err), 32'h1);
    checkOutput("ovf_running", 32'(running), 32'h0);
    checkOutput("ovf_pc", 32'(pc), 32'h60);
    start = 1'b1; applyStimulus(2); start = 1'b0;
    checkOutput("halt_sticky_run", 32'(running), 32'h0);
    checkOutput("halt_sticky_err", 32'(err), 32'h1);
    doReset();
    checkOutput("ovf_cleared", 32'(err), 32'h0);
    startRun();
    checkOutput("load_after_rst", 32'(running), 32'h1);

    // prog_we in RUN is ignored; stop returns to LOAD keeping dout
    doReset();
    progWord(8'h00, OP_LD,   8'hFE);
    progWord(8'h01, OP_STO,  8'hFE);
    progWord(8'h02, OP_NOP0, 8'h00);
    din = 8'h77;
    startRun();
    prog_bus.prog_we = 1'b1; prog_bus.prog_addr = 8'h02; prog_bus.prog_data = {OP_NOPF, 8'h00};
    applyStimulus(2);
    prog_bus.prog_we = 1'b0;
    checkOutput("rom_protected", 32'(opcode), 32'(OP_NOP0));
    checkOutput("stop_pre_dout", 32'(dout), 32'h77);
    stop = 1'b1; applyStimulus(1); stop = 1'b0;
    checkOutput("stop_running", 32'(running), 32'h0);
    checkOutput("stop_pc", 32'(pc), 32'h02);
    checkOutput("stop_no_exec", 32'({flag_o, flag_f}), 32'h0);
    checkOutput("stop_dout", 32'(dout), 32'h77);

    // rst while STO is at pc
    doReset();
    din = 8'h99;
    startRun();
    applyStimulus(1);
    checkOutput("abort_pre_pc", 32'(pc), 32'h01);
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    checkOutput("abort_dout", 32'(dout), 32'h00);
    checkOutput("abort_pc", 32'(pc), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
